// File: rtl/hough_peak_pkg.sv
// Shared Hough pipeline types: scan FSM encoding, default geometry
// and the peak-list entry carried between the peak finder and line-to-corner.
package hough_peak_pkg;

    localparam int DEF_THETA_COUNT  = 180;
    localparam int DEF_RHO_COUNT    = 256;
    localparam int DEF_THETA_BITS   = 8;
    localparam int DEF_RHO_BITS     = 8;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_COUNT_WIDTH  = 8;
    localparam int DEF_NUM_PEAKS    = 4;
    localparam int DEF_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                       valid;
        logic [DEF_COUNT_WIDTH-1:0] value;
        logic [DEF_RHO_BITS-1:0]    rho;
        logic [DEF_THETA_BITS-1:0]  theta;
    } peak_entry_t;

endpackage

// File: rtl/peak_topk_list.sv
// Registered, always-sorted list of the strongest peak entries.
// One insertion per cycle; a strict compare keeps earlier bins ahead on ties.
module peak_topk_list
    import hough_peak_pkg::*;
#(
    parameter int NUM_PEAKS = DEF_NUM_PEAKS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic                        insert_i,
    input  peak_entry_t                 entry_i,
    output peak_entry_t [NUM_PEAKS-1:0] list_o
);

    peak_entry_t [NUM_PEAKS-1:0] list_q, list_d;
    peak_entry_t [NUM_PEAKS-1:0] shifted;
    logic                        seen;

    always_comb begin
        list_d  = list_q;
        seen    = 1'b0;
        shifted = {list_q[NUM_PEAKS-2:0], entry_i};
        if (clear_i) begin
            list_d = '0;
        end else if (insert_i) begin
            // slots below the insertion point move down one place
            for (int i = 0; i < NUM_PEAKS; i++) begin
                if (seen) begin
                    list_d[i] = shifted[i];
                end else if (!list_q[i].valid ||
                             (entry_i.value > list_q[i].value)) begin
                    list_d[i] = entry_i;
                    seen      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            list_q <= '0;
        end else begin
            list_q <= list_d;
        end
    end

    assign list_o = list_q;

endmodule

// File: rtl/hough_peak_finder.sv
// Scans the Hough accumulator once per start and reports the strongest
// bins above threshold as a sorted peak list with a done pulse.
module hough_peak_finder
    import hough_peak_pkg::*;
#(
    parameter int THETA_COUNT  = DEF_THETA_COUNT,
    parameter int RHO_COUNT    = DEF_RHO_COUNT,
    parameter int THETA_BITS   = DEF_THETA_BITS,
    parameter int RHO_BITS     = DEF_RHO_BITS,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int NUM_PEAKS    = DEF_NUM_PEAKS,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            done,
    output logic                            busy,
    input  logic [COUNT_WIDTH-1:0]          threshold,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [COUNT_WIDTH-1:0]          mem_data,
    output logic [NUM_PEAKS*RHO_BITS-1:0]   peak_rho,
    output logic [NUM_PEAKS*THETA_BITS-1:0] peak_theta,
    output logic [NUM_PEAKS*COUNT_WIDTH-1:0] peak_value,
    output logic [NUM_PEAKS-1:0]            peak_valid
);

    localparam int NUM_BINS = THETA_COUNT * RHO_COUNT;
    localparam int DRAIN_W  = $clog2(READ_LATENCY + 2);
    localparam int TAG_W    = 1 + RHO_BITS + THETA_BITS;

    state_t                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  thr_q, thr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [RHO_BITS-1:0]     rho_q, rho_d;
    logic [THETA_BITS-1:0]   theta_q, theta_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic [TAG_W-1:0]        tag_q [READ_LATENCY];
    logic [TAG_W-1:0]        tag_d;
    peak_entry_t             sample_q, sample_d;
    peak_entry_t [NUM_PEAKS-1:0] list;
    logic                    clear;
    logic                    insert;

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        addr_d  = addr_q;
        rho_d   = rho_q;
        theta_d = theta_q;
        drain_d = drain_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    thr_d   = threshold;
                    addr_d  = '0;
                    rho_d   = '0;
                    theta_d = '0;
                    clear   = 1'b1;
                end
            end
            SCAN: begin
                if (rho_q == RHO_BITS'(RHO_COUNT - 1)) begin
                    rho_d   = '0;
                    theta_d = theta_q + 1'b1;
                end else begin
                    rho_d = rho_q + 1'b1;
                end
                if (addr_q == ADDR_WIDTH'(NUM_BINS - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // covers BRAM latency, the sample register and the last insert
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_W'(READ_LATENCY + 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tag_d          = {state_q == SCAN, rho_q, theta_q};
        sample_d.valid = tag_q[READ_LATENCY-1][TAG_W-1];
        sample_d.value = DEF_COUNT_WIDTH'(mem_data);
        sample_d.rho   = DEF_RHO_BITS'(tag_q[READ_LATENCY-1][THETA_BITS +: RHO_BITS]);
        sample_d.theta = DEF_THETA_BITS'(tag_q[READ_LATENCY-1][THETA_BITS-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            thr_q    <= '0;
            addr_q   <= '0;
            rho_q    <= '0;
            theta_q  <= '0;
            drain_q  <= '0;
            sample_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            thr_q    <= thr_d;
            addr_q   <= addr_d;
            rho_q    <= rho_d;
            theta_q  <= theta_d;
            drain_q  <= drain_d;
            sample_q <= sample_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign insert = sample_q.valid &&
                    (sample_q.value > DEF_COUNT_WIDTH'(thr_q));

    peak_topk_list #(
        .NUM_PEAKS (NUM_PEAKS)
    ) u_list (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear),
        .insert_i (insert),
        .entry_i  (sample_q),
        .list_o   (list)
    );

    assign done     = (state_q == DONE);
    assign busy     = (state_q == SCAN) || (state_q == DRAIN);
    assign mem_addr = addr_q;

    for (genvar i = 0; i < NUM_PEAKS; i++) begin : g_out
        assign peak_rho[i*RHO_BITS +: RHO_BITS]          = RHO_BITS'(list[i].rho);
        assign peak_theta[i*THETA_BITS +: THETA_BITS]    = THETA_BITS'(list[i].theta);
        assign peak_value[i*COUNT_WIDTH +: COUNT_WIDTH]  = COUNT_WIDTH'(list[i].value);
        assign peak_valid[i]                             = list[i].valid;
    end

endmodule

// File: tb/tb_hough_peak_finder.sv
// Directed bench for hough_peak_finder on a 4x8 accumulator
// with a two-cycle behavioural BRAM.
module tb_hough_peak_finder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        busy;
    logic [7:0]  threshold;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [31:0] peak_rho;
    logic [31:0] peak_theta;
    logic [31:0] peak_value;
    logic [3:0]  peak_valid;

    logic [7:0]  mem [32];
    logic [7:0]  rd1;

    int n_vec = 0;
    int n_err = 0;
    int done_at;
    int n_done;
    logic busy_ok;

    always #5 clk = ~clk;

    hough_peak_finder #(
        .THETA_COUNT  (4),
        .RHO_COUNT    (8),
        .THETA_BITS   (8),
        .RHO_BITS     (8),
        .ADDR_WIDTH   (16),
        .COUNT_WIDTH  (8),
        .NUM_PEAKS    (4),
        .READ_LATENCY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .threshold  (threshold),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .peak_rho   (peak_rho),
        .peak_theta (peak_theta),
        .peak_value (peak_value),
        .peak_valid (peak_valid)
    );

    // two-stage registered read port
    always @(posedge clk) begin
        rd1      <= mem[mem_addr[4:0]];
        mem_data <= rd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    endtask

    task automatic set_bin(input int theta, input int rho, input logic [7:0] v);
        mem[theta*8 + rho] = v;
    endtask

    task automatic run_scan(input logic [7:0] thr, input int poke_at,
                            input int rst_at);
        done_at = -1;
        n_done  = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        threshold = thr;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = n;
                if (busy) busy_ok = 1'b0;
            end else if (done_at < 0 && rst_at == 0 && !busy) begin
                busy_ok = 1'b0;
            end
            start = (n == poke_at);
            reset = (n == rst_at);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic load_six();
        clear_mem();
        set_bin(0, 1, 8'd7);
        set_bin(0, 4, 8'd12);
        set_bin(1, 1, 8'd12);
        set_bin(1, 5, 8'd3);
        set_bin(2, 4, 8'd20);
        set_bin(3, 6, 8'd5);
    endtask

    task automatic check_six(input string tag);
        chk({tag, "_valid"}, {28'd0, peak_valid}, 32'h0000000F);
        chk({tag, "_value"}, peak_value, 32'h070C0C14);
        chk({tag, "_rho"},   peak_rho,   32'h01010404);
        chk({tag, "_theta"}, peak_theta, 32'h00010002);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        threshold = 8'd0;
        rd1       = 8'd0;
        mem_data  = 8'd0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst_valid", {28'd0, peak_valid}, 32'd0);
        chk("rst_value", peak_value, 32'd0);
        chk("rst_rho",   peak_rho | peak_theta, 32'd0);

        // all-zero memory, threshold 0
        run_scan(8'd0, 0, 0);
        chk("zero_latency", done_at, 36);
        chk("zero_ndone",   n_done, 1);
        chk("zero_busy",    {31'd0, busy_ok}, 32'd1);
        chk("zero_valid",   {28'd0, peak_valid}, 32'd0);

        // single bin
        clear_mem();
        set_bin(2, 5, 8'd9);
        run_scan(8'd3, 0, 0);
        chk("one_valid", {28'd0, peak_valid}, 32'h1);
        chk("one_value", {24'd0, peak_value[7:0]}, 32'd9);
        chk("one_rho",   {24'd0, peak_rho[7:0]}, 32'd5);
        chk("one_theta", {24'd0, peak_theta[7:0]}, 32'd2);

        // six bins, ties keep scan order
        load_six();
        run_scan(8'd4, 0, 0);
        chk("six_latency", done_at, 36);
        check_six("six");

        // equal to threshold is rejected
        clear_mem();
        set_bin(0, 3, 8'd6);
        set_bin(2, 1, 8'd7);
        run_scan(8'd6, 0, 0);
        chk("eq_valid", {28'd0, peak_valid}, 32'h1);
        chk("eq_value", {24'd0, peak_value[7:0]}, 32'd7);
        chk("eq_idx",   {16'd0, peak_theta[7:0], peak_rho[7:0]}, 32'h0201);

        // second start mid-scan is ignored
        load_six();
        run_scan(8'd4, 10, 0);
        chk("poke_latency", done_at, 36);
        chk("poke_ndone",   n_done, 1);
        check_six("poke");

        // reset mid-scan aborts, then a fresh scan completes
        run_scan(8'd4, 0, 15);
        chk("abort_ndone", n_done, 0);
        chk("abort_valid", {28'd0, peak_valid}, 32'd0);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        run_scan(8'd4, 0, 0);
        chk("fresh_latency", done_at, 36);
        chk("fresh_ndone",   n_done, 1);
        chk("fresh_busy",    {31'd0, busy_ok}, 32'd1);
        check_six("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
